pc_generator: RTL and testbench

//  Next-PC producer for the fetch path. Drives PC_IN / PC_VALID_IN of the instruction fetch stage register.

---
 rtl/pc_generator_if.sv | 28 ++
 rtl/pc_generator.sv | 147 ++++++++++++++
 tb/tb_pc_generator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_generator_if.sv
// Fetch-PC bundle between the next-PC generator (master) and the fetch/execute side (slave).
// Signal names match the pc_generator port list one-to-one.
interface pc_generator_if #(
    parameter int unsigned ADDRESS_WIDTH = 32
);
    logic                     STALL_PC;
    logic                     HALT_REQ;
    logic                     REDIRECT_VALID;
    logic [ADDRESS_WIDTH-1:0] REDIRECT_PC;
    logic                     BTB_UPDATE_VALID;
    logic [ADDRESS_WIDTH-1:0] BTB_UPDATE_PC;
    logic [ADDRESS_WIDTH-1:0] BTB_UPDATE_TARGET;
    logic [ADDRESS_WIDTH-1:0] PC_OUT;
    logic                     PC_VALID_OUT;
    logic                     PREDICTED_TAKEN_OUT;

    modport master (
        input  STALL_PC, HALT_REQ, REDIRECT_VALID, REDIRECT_PC,
        input  BTB_UPDATE_VALID, BTB_UPDATE_PC, BTB_UPDATE_TARGET,
        output PC_OUT, PC_VALID_OUT, PREDICTED_TAKEN_OUT
    );

    modport slave (
        output STALL_PC, HALT_REQ, REDIRECT_VALID, REDIRECT_PC,
        output BTB_UPDATE_VALID, BTB_UPDATE_PC, BTB_UPDATE_TARGET,
        input  PC_OUT, PC_VALID_OUT, PREDICTED_TAKEN_OUT
    );
endinterface

// File: rtl/pc_generator.sv
// Fetch-path next-PC generator: reset-vector boot, +4 stepping, redirect, stall and halt.
// Define PC_GEN_BTB_EN to add a direct-mapped BTB that predicts taken branches at fetch.
module pc_generator #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter int unsigned              BOOT_CYCLES   = 2,
    parameter int unsigned              BTB_ENTRIES   = 16
) (
    input logic            CLK,
    input logic            RST,
    pc_generator_if.master bus
);
    localparam int unsigned CntW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CntW-1:0] BootLast = CntW'(BOOT_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ResetPc = {RESET_VECTOR[ADDRESS_WIDTH-1:2], 2'b00};

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     valid_q, valid_d;
    logic                     pred_q, pred_d;

    logic                     btb_hit;
    logic [ADDRESS_WIDTH-1:0] btb_target;
    logic [ADDRESS_WIDTH-1:0] next_pc;
    logic                     unused_low_bits;

    // Redirect targets are word-aligned; the dropped bits are intentionally ignored.
    assign unused_low_bits = ^bus.REDIRECT_PC[1:0];

`ifdef PC_GEN_BTB_EN
    localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
    localparam int unsigned TagW = ADDRESS_WIDTH - 2 - IdxW;

    logic [BTB_ENTRIES-1:0]   btb_valid_q, btb_valid_d;
    logic [TagW-1:0]          btb_tag_q [BTB_ENTRIES];
    logic [TagW-1:0]          btb_tag_d [BTB_ENTRIES];
    logic [ADDRESS_WIDTH-3:0] btb_tgt_q [BTB_ENTRIES];
    logic [ADDRESS_WIDTH-3:0] btb_tgt_d [BTB_ENTRIES];
    logic [IdxW-1:0]          look_idx;
    logic [IdxW-1:0]          upd_idx;
    logic                     unused_btb;

    assign look_idx   = pc_q[2 +: IdxW];
    assign upd_idx    = bus.BTB_UPDATE_PC[2 +: IdxW];
    assign btb_hit    = btb_valid_q[look_idx] &&
                        (btb_tag_q[look_idx] == pc_q[ADDRESS_WIDTH-1 -: TagW]);
    assign btb_target = {btb_tgt_q[look_idx], 2'b00};
    assign unused_btb = ^{bus.BTB_UPDATE_PC[1:0], bus.BTB_UPDATE_TARGET[1:0]};

    // Lookup reads the _q arrays, so a same-cycle update is only visible next cycle.
    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        if (bus.BTB_UPDATE_VALID) begin
            btb_valid_d[upd_idx] = 1'b1;
            btb_tag_d[upd_idx]   = bus.BTB_UPDATE_PC[ADDRESS_WIDTH-1 -: TagW];
            btb_tgt_d[upd_idx]   = bus.BTB_UPDATE_TARGET[ADDRESS_WIDTH-1:2];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btb_valid_q <= '0;
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
            end
        end else begin
            btb_valid_q <= btb_valid_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
        end
    end
`else
    logic unused_btb;

    assign btb_hit    = 1'b0;
    assign btb_target = '0;
    assign unused_btb = ^{bus.BTB_UPDATE_VALID, bus.BTB_UPDATE_PC, bus.BTB_UPDATE_TARGET,
                          (BTB_ENTRIES != 32'd0)};
`endif

    assign next_pc = btb_hit ? btb_target : pc_q + ADDRESS_WIDTH'(4);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        pred_d  = pred_q;
        if (bus.REDIRECT_VALID) begin
            state_d = StRun;
            pc_d    = {bus.REDIRECT_PC[ADDRESS_WIDTH-1:2], 2'b00};
            valid_d = 1'b1;
            pred_d  = 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    // Boot ignores stall and halt; it only counts down to the first fetch.
                    if (cnt_q == BootLast) begin
                        state_d = StRun;
                        pc_d    = ResetPc;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    if (bus.HALT_REQ) begin
                        state_d = StHalt;
                        valid_d = 1'b0;
                        pred_d  = 1'b0;
                    end else if (!bus.STALL_PC) begin
                        pc_d   = next_pc;
                        pred_d = btb_hit;
                    end
                end
                StHalt: ;
                default: state_d = StBoot;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StBoot;
            cnt_q   <= '0;
            pc_q    <= ResetPc;
            valid_q <= 1'b0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            pred_q  <= pred_d;
        end
    end

    assign bus.PC_OUT              = pc_q;
    assign bus.PC_VALID_OUT        = valid_q;
    assign bus.PREDICTED_TAKEN_OUT = pred_q;
endmodule

// File: tb/tb_pc_generator.sv
// Bench for pc_generator: directed fetch scenarios, then randomized traffic against a
// behavioural model (boot countdown, halt flag, and a slot->branch-PC table for the BTB).
module tb_pc_generator;
    localparam int unsigned W          = 32;
    localparam int unsigned BootCycles = 2;
    localparam int unsigned BtbEntries = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    pc_generator_if #(.ADDRESS_WIDTH(W)) bus ();

    pc_generator #(
        .ADDRESS_WIDTH(W),
        .RESET_VECTOR (32'h0000_0000),
        .BOOT_CYCLES  (BootCycles),
        .BTB_ENTRIES  (BtbEntries)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pred;
    logic        m_halted;
    int          m_boot_left;
    logic        mb_valid  [BtbEntries];
    logic [31:0] mb_branch [BtbEntries];
    logic [31:0] mb_tgt    [BtbEntries];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_pc"}, bus.PC_OUT, m_pc);
        check({tag, "_valid"}, {31'd0, bus.PC_VALID_OUT}, {31'd0, m_valid});
        check({tag, "_pred"}, {31'd0, bus.PREDICTED_TAKEN_OUT}, {31'd0, m_pred});
    endtask

    task automatic model_reset();
        m_pc        = 32'h0;
        m_valid     = 1'b0;
        m_pred      = 1'b0;
        m_halted    = 1'b0;
        m_boot_left = BootCycles;
        for (int i = 0; i < int'(BtbEntries); i++) mb_valid[i] = 1'b0;
    endtask

    task automatic model_edge(input logic stall, input logic halt, input logic redir,
                              input logic [31:0] rpc, input logic upd,
                              input logic [31:0] upc, input logic [31:0] utgt);
        int          slot;
        logic        hit;
        logic [31:0] tgt;
        slot = int'((m_pc / 4) % BtbEntries);
        hit  = 1'b0;
        tgt  = mb_tgt[slot] & ~32'h3;
`ifdef PC_GEN_BTB_EN
        hit = mb_valid[slot] && (mb_branch[slot] == m_pc);
`endif
        if (redir) begin
            m_pc = rpc & ~32'h3; m_valid = 1'b1; m_pred = 1'b0;
            m_boot_left = 0; m_halted = 1'b0;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
            if (m_boot_left == 0) begin
                m_valid = 1'b1; m_pc = 32'h0;
            end
        end else if (m_halted) begin
            // only a redirect leaves halt
        end else if (halt) begin
            m_halted = 1'b1; m_valid = 1'b0; m_pred = 1'b0;
        end else if (!stall) begin
            m_pc   = hit ? tgt : m_pc + 32'd4;
            m_pred = hit;
        end
        if (upd) begin
            slot = int'((upc / 4) % BtbEntries);
            mb_valid[slot]  = 1'b1;
            mb_branch[slot] = upc & ~32'h3;
            mb_tgt[slot]    = utgt;
        end
    endtask

    task automatic step(input string tag, input logic stall, input logic halt,
                        input logic redir, input logic [31:0] rpc, input logic upd,
                        input logic [31:0] upc, input logic [31:0] utgt);
        bus.STALL_PC          = stall;
        bus.HALT_REQ          = halt;
        bus.REDIRECT_VALID    = redir;
        bus.REDIRECT_PC       = rpc;
        bus.BTB_UPDATE_VALID  = upd;
        bus.BTB_UPDATE_PC     = upc;
        bus.BTB_UPDATE_TARGET = utgt;
        @(posedge CLK);
        model_edge(stall, halt, redir, rpc, upd, upc, utgt);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic redirect(input string tag, input logic [31:0] pc);
        step(tag, 1'b0, 1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset(input string tag);
        RST = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        logic        r, h, s, u;
        logic [31:0] rpc, upc, utgt;
        bus.STALL_PC = 1'b0; bus.HALT_REQ = 1'b0; bus.REDIRECT_VALID = 1'b0;
        bus.REDIRECT_PC = '0; bus.BTB_UPDATE_VALID = 1'b0;
        bus.BTB_UPDATE_PC = '0; bus.BTB_UPDATE_TARGET = '0;
        #2;
        apply_reset("reset");
        check("reset_pc", bus.PC_OUT, 32'h0);
        check("reset_valid", {31'd0, bus.PC_VALID_OUT}, 32'd0);

        // Boot: valid low for two cycles, halt during boot is ignored.
        idle("boot1");
        check("boot1_valid", {31'd0, bus.PC_VALID_OUT}, 32'd0);
        step("boot2_halt", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("boot_done_valid", {31'd0, bus.PC_VALID_OUT}, 32'd1);
        check("boot_done_pc", bus.PC_OUT, 32'h0);
        idle("seq4");  check("seq_4", bus.PC_OUT, 32'h4);
        idle("seq8");  check("seq_8", bus.PC_OUT, 32'h8);
        idle("seqC");  check("seq_c", bus.PC_OUT, 32'hC);
        idle("seq10"); check("seq_10", bus.PC_OUT, 32'h10);

        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            check("stall_pc", bus.PC_OUT, 32'h10);
            check("stall_valid", {31'd0, bus.PC_VALID_OUT}, 32'd1);
        end
        idle("unstall"); check("unstall_pc", bus.PC_OUT, 32'h14);

        step("redir_prio", 1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0, 32'h0);
        check("redir_prio_pc", bus.PC_OUT, 32'h200);
        check("redir_prio_valid", {31'd0, bus.PC_VALID_OUT}, 32'd1);
        idle("after_redir"); check("after_redir_pc", bus.PC_OUT, 32'h204);

        redirect("to40", 32'h40);
        step("halt", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step("halted", i[0], 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            check("halted_pc", bus.PC_OUT, 32'h40);
            check("halted_valid", {31'd0, bus.PC_VALID_OUT}, 32'd0);
        end
        redirect("unhalt", 32'h80);
        check("unhalt_pc", bus.PC_OUT, 32'h80);
        check("unhalt_valid", {31'd0, bus.PC_VALID_OUT}, 32'd1);

        redirect("to_top", 32'hFFFF_FFFC);
        idle("wrap"); check("wrap_pc", bus.PC_OUT, 32'h0);

        // BTB scenario (prediction only exists when the BTB is built in).
        step("btb_upd", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'h400);
        redirect("toFC", 32'hFC);
        idle("at100"); check("at100_pc", bus.PC_OUT, 32'h100);
        idle("btb_step");
`ifdef PC_GEN_BTB_EN
        check("btb_hit_pc", bus.PC_OUT, 32'h400);
        check("btb_hit_pred", {31'd0, bus.PREDICTED_TAKEN_OUT}, 32'd1);
`else
        check("nobtb_pc", bus.PC_OUT, 32'h104);
        check("nobtb_pred", {31'd0, bus.PREDICTED_TAKEN_OUT}, 32'd0);
`endif
        idle("after_btb");
        redirect("to200", 32'h200);
        step("same_cyc_upd", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 32'h300);
        check("same_cyc_old", bus.PC_OUT, 32'h204);
        redirect("to200b", 32'h200);
        idle("new_entry");

        // Reset mid-boot and mid-run clears the BTB.
        apply_reset("rst_run");
        idle("reboot1");
        apply_reset("rst_boot");
        idle("reboot_a");
        idle("reboot_b");
        check("reboot_pc", bus.PC_OUT, 32'h0);
        redirect("to100", 32'h100);
        idle("miss100");
        check("miss100_pc", bus.PC_OUT, 32'h104);
        check("miss100_pred", {31'd0, bus.PREDICTED_TAKEN_OUT}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset("rnd_rst");
            end else begin
                r    = ($urandom_range(0, 15) == 0);
                h    = ($urandom_range(0, 31) == 0);
                s    = ($urandom_range(0, 3) == 0);
                u    = ($urandom_range(0, 3) == 0);
                rpc  = $urandom_range(0, 1023);
                upc  = $urandom_range(0, 1023);
                utgt = $urandom_range(0, 1023);
                step("rnd", s, h, r, rpc, u, upc, utgt);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
